// File: rtl/otter_dmem_arbiter_pkg.sv
// ---------------------------------------------------------------------------------------------
// otter_dmem_arbiter_pkg
//   Shared types for the OTTER data-port arbiter: the 4-bit access command layout, the access
//   size encoding, the arbitration state encoding and the master identifier.
//   No ports (package).
// ---------------------------------------------------------------------------------------------
package otter_dmem_arbiter_pkg;

    // Access size as seen by the memory's data port.
    typedef enum logic [1:0] {
        SizeByte = 2'd0,
        SizeHalf = 2'd1,
        SizeWord = 2'd2
    } mem_size_e;

    // Command word carried on M0_CMD / M1_CMD: {WE, SIGN, SIZE[1:0]}.
    typedef struct packed {
        logic      we;
        logic      sign;
        mem_size_e size;
    } cmd_t;

    typedef enum logic [1:0] {
        IdleRr   = 2'd0,
        M1Locked = 2'd1,
        ForceM0  = 2'd2
    } arb_state_e;

    typedef enum logic {
        OwnerM0 = 1'b0,
        OwnerM1 = 1'b1
    } owner_e;

    // A granted command expects read data back only when it is not a store.
    function automatic logic cmd_is_read(input cmd_t cmd);
        return ~cmd.we;
    endfunction

endpackage

// File: rtl/otter_dmem_arbiter_if.sv
// ---------------------------------------------------------------------------------------------
// otter_dmem_arbiter_if
//   Bundles both master request channels, their grant/read-return signals and the memory's
//   port-2 signals.
//   modport slave  : arbiter view (takes requests and MEM_DOUT2, drives grants and MEM_*)
//   modport master : surrounding view (masters + memory)
//   M0_*/M1_*  : REQ, CMD {WE,SIGN,SIZE}, ADDR, WDATA in; GNT, RVALID, RDATA out (M1 adds LOCK)
//   MEM_*      : ADDR2, DIN2, WRITE2, READ2, SIZE, SIGN out; DOUT2 in (one cycle after READ2)
// ---------------------------------------------------------------------------------------------
interface otter_dmem_arbiter_if;

    logic        M0_REQ;
    logic [3:0]  M0_CMD;
    logic [31:0] M0_ADDR;
    logic [31:0] M0_WDATA;
    logic        M0_GNT;
    logic        M0_RVALID;
    logic [31:0] M0_RDATA;

    logic        M1_REQ;
    logic        M1_LOCK;
    logic [3:0]  M1_CMD;
    logic [31:0] M1_ADDR;
    logic [31:0] M1_WDATA;
    logic        M1_GNT;
    logic        M1_RVALID;
    logic [31:0] M1_RDATA;

    logic [31:0] MEM_ADDR2;
    logic [31:0] MEM_DIN2;
    logic        MEM_WRITE2;
    logic        MEM_READ2;
    logic [1:0]  MEM_SIZE;
    logic        MEM_SIGN;
    logic [31:0] MEM_DOUT2;

    modport slave (
        input  M0_REQ, M0_CMD, M0_ADDR, M0_WDATA,
        input  M1_REQ, M1_LOCK, M1_CMD, M1_ADDR, M1_WDATA,
        input  MEM_DOUT2,
        output M0_GNT, M0_RVALID, M0_RDATA,
        output M1_GNT, M1_RVALID, M1_RDATA,
        output MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

    modport master (
        output M0_REQ, M0_CMD, M0_ADDR, M0_WDATA,
        output M1_REQ, M1_LOCK, M1_CMD, M1_ADDR, M1_WDATA,
        output MEM_DOUT2,
        input  M0_GNT, M0_RVALID, M0_RDATA,
        input  M1_GNT, M1_RVALID, M1_RDATA,
        input  MEM_ADDR2, MEM_DIN2, MEM_WRITE2, MEM_READ2, MEM_SIZE, MEM_SIGN
    );

endinterface

// File: rtl/otter_dmem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// otter_dmem_arbiter
//   Shares OTTER memory data port 2 between M0 (CPU load/store) and M1 (DMA/programmer).
//   One grant per cycle at most; the granted command is forwarded to MEM_* in the same cycle,
//   and read data returns to the owner one cycle later with an RVALID strobe.
//   Arbitration: round-robin when idle; M1 may hold strict priority with M1_LOCK, bounded by
//   MAX_LOCK consecutive M1 grants, after which one M0 grant is forced.
//   Ports:
//     CLK  : clock, all state on posedge
//     RST  : synchronous active-high reset; also masks every output while asserted
//     bus  : otter_dmem_arbiter_if.slave (master channels + memory port 2)
//   Addresses are not decoded; the IO region is forwarded like any other address.
// ---------------------------------------------------------------------------------------------
module otter_dmem_arbiter
    import otter_dmem_arbiter_pkg::*;
#(
    parameter int unsigned MAX_LOCK = 8
) (
    input logic                 CLK,
    input logic                 RST,
    otter_dmem_arbiter_if.slave bus
);

    localparam int unsigned     CntW    = $clog2(MAX_LOCK + 1);
    localparam logic [CntW-1:0] LockMax = CntW'(MAX_LOCK);

    arb_state_e      state_q;
    owner_e          last_winner_q;
    logic [CntW-1:0] lock_cnt_q;
    logic [CntW-1:0] cnt_after;
    logic            rd_pend_q;
    owner_e          rd_owner_q;

    logic            gnt0;
    logic            gnt1;
    logic            any_gnt;
    cmd_t            m0_cmd;
    cmd_t            m1_cmd;
    cmd_t            sel_cmd;
    logic            rvalid;
    logic            rvalid0;
    logic            rvalid1;

    assign m0_cmd = cmd_t'(bus.M0_CMD);
    assign m1_cmd = cmd_t'(bus.M1_CMD);

    // ---------------------------------------------------------------------------------------
    // Grant decision (combinational from requests and registered state)
    // ---------------------------------------------------------------------------------------
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!RST) begin
            unique case (state_q)
                IdleRr: begin
                    if (bus.M0_REQ && bus.M1_REQ) begin
                        // Tie goes to whoever did not win last.
                        if (last_winner_q == OwnerM1) gnt0 = 1'b1;
                        else                          gnt1 = 1'b1;
                    end else begin
                        gnt0 = bus.M0_REQ;
                        gnt1 = bus.M1_REQ;
                    end
                end
                M1Locked: begin
                    gnt1 = bus.M1_REQ;
                    gnt0 = bus.M0_REQ & ~bus.M1_REQ;
                end
                ForceM0: begin
                    gnt0 = bus.M0_REQ;
                end
                default: begin
                    gnt0 = 1'b0;
                    gnt1 = 1'b0;
                end
            endcase
        end
    end

    assign any_gnt = gnt0 | gnt1;

    // Lock counter value after this cycle's grant; saturates instead of wrapping.
    assign cnt_after = (gnt1 && (lock_cnt_q != LockMax)) ? lock_cnt_q + CntW'(1) : lock_cnt_q;

    // ---------------------------------------------------------------------------------------
    // Command forwarding to memory port 2
    // ---------------------------------------------------------------------------------------
    always_comb begin
        sel_cmd        = '0;
        bus.MEM_ADDR2  = '0;
        bus.MEM_DIN2   = '0;
        if (gnt0) begin
            sel_cmd       = m0_cmd;
            bus.MEM_ADDR2 = bus.M0_ADDR;
            bus.MEM_DIN2  = bus.M0_WDATA;
        end else if (gnt1) begin
            sel_cmd       = m1_cmd;
            bus.MEM_ADDR2 = bus.M1_ADDR;
            bus.MEM_DIN2  = bus.M1_WDATA;
        end
    end

    assign bus.MEM_READ2  = any_gnt & cmd_is_read(sel_cmd);
    assign bus.MEM_WRITE2 = any_gnt & sel_cmd.we;
    assign bus.MEM_SIZE   = sel_cmd.size;
    assign bus.MEM_SIGN   = sel_cmd.sign;
    assign bus.M0_GNT     = gnt0;
    assign bus.M1_GNT     = gnt1;

    // ---------------------------------------------------------------------------------------
    // FSM, round-robin history, lock counter and read-return pipe
    // ---------------------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q       <= IdleRr;
            last_winner_q <= OwnerM1;
            lock_cnt_q    <= '0;
            rd_pend_q     <= 1'b0;
            rd_owner_q    <= OwnerM0;
        end else begin
            if (gnt0)      last_winner_q <= OwnerM0;
            else if (gnt1) last_winner_q <= OwnerM1;

            rd_pend_q  <= any_gnt & cmd_is_read(sel_cmd);
            rd_owner_q <= gnt1 ? OwnerM1 : OwnerM0;

            unique case (state_q)
                IdleRr: begin
                    if (gnt1 && bus.M1_LOCK) begin
                        lock_cnt_q <= cnt_after;
                        // With MAX_LOCK == 1 the entering grant already exhausts the budget.
                        if ((cnt_after == LockMax) && bus.M0_REQ) state_q <= ForceM0;
                        else                                      state_q <= M1Locked;
                    end
                end
                M1Locked: begin
                    if (!bus.M1_LOCK) begin
                        state_q    <= IdleRr;
                        lock_cnt_q <= '0;
                    end else begin
                        lock_cnt_q <= cnt_after;
                        if ((cnt_after == LockMax) && bus.M0_REQ) state_q <= ForceM0;
                    end
                end
                ForceM0: begin
                    // One cycle here whether or not M0 still wanted the slot.
                    lock_cnt_q <= '0;
                    state_q    <= bus.M1_LOCK ? M1Locked : IdleRr;
                end
                default: begin
                    state_q    <= IdleRr;
                    lock_cnt_q <= '0;
                end
            endcase
        end
    end

    // ---------------------------------------------------------------------------------------
    // Read return; masked by RST so a read in flight at reset never reports valid.
    // ---------------------------------------------------------------------------------------
    assign rvalid  = rd_pend_q & ~RST;
    assign rvalid0 = rvalid & (rd_owner_q == OwnerM0);
    assign rvalid1 = rvalid & (rd_owner_q == OwnerM1);

    assign bus.M0_RVALID = rvalid0;
    assign bus.M1_RVALID = rvalid1;
    assign bus.M0_RDATA  = rvalid0 ? bus.MEM_DOUT2 : '0;
    assign bus.M1_RDATA  = rvalid1 ? bus.MEM_DOUT2 : '0;

endmodule

// File: tb/tb_otter_dmem_arbiter.sv
// ---------------------------------------------------------------------------------------------
// tb_otter_dmem_arbiter
//   Drives both masters and a small word memory behind port 2, and compares every cycle
//   against a rule-level model of the arbitration policy and read return, plus directed
//   scenarios with hand-derived expectations.
// ---------------------------------------------------------------------------------------------
module tb_otter_dmem_arbiter;

    localparam int MaxLock = 8;

    logic CLK = 1'b0;
    logic RST;
    bit   mem_clr;

    always #5 CLK = ~CLK;

    otter_dmem_arbiter_if bus ();

    otter_dmem_arbiter #(
        .MAX_LOCK (MaxLock)
    ) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    // Memory behind port 2: 16 words indexed by ADDR[5:2]; garbage on DOUT2 when not reading.
    logic [31:0] mem [16];

    always @(posedge CLK) begin
        if (mem_clr) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'hA500_0000 | 32'(i);
        end else if (bus.MEM_WRITE2) begin
            mem[bus.MEM_ADDR2[5:2]] <= bus.MEM_DIN2;
        end
        bus.MEM_DOUT2 <= bus.MEM_READ2 ? mem[bus.MEM_ADDR2[5:2]] : $urandom();
    end

    int n_chk = 0;
    int n_bad = 0;

    // Reference model state.
    logic [31:0] shadow [16];
    int          ref_last;
    int          ref_burst;
    bit          ref_locked;
    bit          ref_forcing;
    bit          ref_pv0;
    bit          ref_pv1;
    logic [31:0] ref_pdata;

    // Observations from the most recent checked cycle.
    logic        snap_gnt0, snap_gnt1, snap_rd, snap_we, snap_rv0, snap_rv1;
    logic [1:0]  snap_size;
    logic [31:0] snap_addr, snap_rd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic ref_reset();
        ref_last    = 1;
        ref_burst   = 0;
        ref_locked  = 1'b0;
        ref_forcing = 1'b0;
        ref_pv0     = 1'b0;
        ref_pv1     = 1'b0;
        ref_pdata   = '0;
    endtask

    // One clock: check at negedge, advance model, return at posedge+1 with granted REQ dropped.
    task automatic step(output int g);
        logic [3:0]  c;
        logic [31:0] a, w;
        bit          gv, rv0, rv1;
        @(negedge CLK);
        if (RST)              g = -1;
        else if (ref_forcing) g = bus.M0_REQ ? 0 : -1;
        else if (ref_locked)  g = bus.M1_REQ ? 1 : (bus.M0_REQ ? 0 : -1);
        else if (bus.M0_REQ && bus.M1_REQ) g = (ref_last == 1) ? 0 : 1;
        else                  g = bus.M0_REQ ? 0 : (bus.M1_REQ ? 1 : -1);
        gv = (g >= 0);
        c  = (g == 0) ? bus.M0_CMD   : (g == 1) ? bus.M1_CMD   : 4'd0;
        a  = (g == 0) ? bus.M0_ADDR  : (g == 1) ? bus.M1_ADDR  : 32'd0;
        w  = (g == 0) ? bus.M0_WDATA : (g == 1) ? bus.M1_WDATA : 32'd0;
        rv0 = !RST && ref_pv0;
        rv1 = !RST && ref_pv1;

        check("m0_gnt",     32'(bus.M0_GNT),     32'(g == 0));
        check("m1_gnt",     32'(bus.M1_GNT),     32'(g == 1));
        check("mem_read",   32'(bus.MEM_READ2),  32'(gv && !c[3]));
        check("mem_write",  32'(bus.MEM_WRITE2), 32'(gv && c[3]));
        check("mem_addr",   bus.MEM_ADDR2,       a);
        check("mem_din",    bus.MEM_DIN2,        w);
        check("mem_size",   32'(bus.MEM_SIZE),   32'(c[1:0]));
        check("mem_sign",   32'(bus.MEM_SIGN),   32'(c[2]));
        check("m0_rvalid",  32'(bus.M0_RVALID),  32'(rv0));
        check("m1_rvalid",  32'(bus.M1_RVALID),  32'(rv1));
        check("m0_rdata",   bus.M0_RDATA,        rv0 ? ref_pdata : 32'd0);
        check("m1_rdata",   bus.M1_RDATA,        rv1 ? ref_pdata : 32'd0);

        snap_gnt0 = bus.M0_GNT;     snap_gnt1 = bus.M1_GNT;
        snap_rd   = bus.MEM_READ2;  snap_we   = bus.MEM_WRITE2;
        snap_addr = bus.MEM_ADDR2;  snap_size = bus.MEM_SIZE;
        snap_rv0  = bus.M0_RVALID;  snap_rv1  = bus.M1_RVALID;
        snap_rd0  = bus.M0_RDATA;

        if (RST) begin
            ref_reset();
        end else begin
            ref_pv0 = (g == 0) && !c[3];
            ref_pv1 = (g == 1) && !c[3];
            if (gv && !c[3]) ref_pdata = shadow[a[5:2]];
            if (gv && c[3])  shadow[a[5:2]] = w;
            if (gv) ref_last = g;
            if (ref_forcing) begin
                ref_forcing = 1'b0;
                ref_burst   = 0;
                ref_locked  = bus.M1_LOCK;
            end else if (ref_locked && !bus.M1_LOCK) begin
                ref_locked = 1'b0;
                ref_burst  = 0;
            end else if (ref_locked || (g == 1 && bus.M1_LOCK)) begin
                ref_locked = 1'b1;
                if (g == 1 && ref_burst < MaxLock) ref_burst++;
                if (ref_burst == MaxLock && bus.M0_REQ) begin
                    ref_forcing = 1'b1;
                    ref_locked  = 1'b0;
                end
            end
        end

        @(posedge CLK);
        #1;
        if (g == 0) bus.M0_REQ = 1'b0;
        if (g == 1) bus.M1_REQ = 1'b0;
    endtask

    task automatic rand_cmd(output logic [3:0] cmd, output logic [31:0] addr,
                            output logic [31:0] wd);
        cmd  = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 2))};
        addr = ($urandom_range(0, 7) == 0) ? 32'h1100_0000
                                           : 32'h100 + 32'($urandom_range(0, 15)) * 32'd4;
        wd   = $urandom();
    endtask

    task automatic do_reset();
        int g;
        RST = 1'b1;
        step(g);
        RST = 1'b0;
    endtask

    initial begin
        int g;
        mem_clr      = 1'b1;
        RST          = 1'b1;
        bus.M0_REQ   = 1'b0; bus.M0_CMD = '0; bus.M0_ADDR = '0; bus.M0_WDATA = '0;
        bus.M1_REQ   = 1'b0; bus.M1_CMD = '0; bus.M1_ADDR = '0; bus.M1_WDATA = '0;
        bus.M1_LOCK  = 1'b0;
        for (int i = 0; i < 16; i++) shadow[i] = 32'hA500_0000 | 32'(i);
        ref_reset();
        @(posedge CLK);
        #1;
        step(g);
        mem_clr = 1'b0;

        // Requests during reset must not be granted.
        bus.M0_REQ = 1'b1; bus.M1_REQ = 1'b1;
        step(g);
        check("rst_gnt0", 32'(snap_gnt0), 32'd0);
        check("rst_gnt1", 32'(snap_gnt1), 32'd0);
        RST = 1'b0;
        bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
        step(g);

        // Single M0 load from 0x100.
        bus.M0_REQ = 1'b1; bus.M0_CMD = 4'b0010; bus.M0_ADDR = 32'h100;
        step(g);
        check("rd_gnt0", 32'(snap_gnt0), 32'd1);
        check("rd_read", 32'(snap_rd), 32'd1);
        step(g);
        check("rd_rvalid", 32'(snap_rv0), 32'd1);
        check("rd_rdata", snap_rd0, 32'hA500_0000);

        // Both requesting every cycle, no lock: strict alternation starting with M0.
        do_reset();
        bus.M0_CMD = 4'b0010; bus.M1_CMD = 4'b0110;
        for (int k = 0; k < 8; k++) begin
            bus.M0_REQ = 1'b1; bus.M0_ADDR = 32'h100 + 32'(k) * 32'd4;
            bus.M1_REQ = 1'b1; bus.M1_ADDR = 32'h120 + 32'(k) * 32'd4;
            step(g);
            check("alt_seq", 32'(g), 32'(k % 2));
        end
        bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
        step(g);

        // Locked burst: M0 (tie), 8 x M1, forced M0, 8 x M1, forced M0.
        do_reset();
        bus.M1_LOCK = 1'b1;
        for (int k = 0; k < 19; k++) begin
            bus.M0_REQ = 1'b1; bus.M1_REQ = 1'b1;
            step(g);
            check("lock_seq", 32'(g), (k == 0 || k == 9 || k == 18) ? 32'd0 : 32'd1);
        end
        bus.M1_LOCK = 1'b0; bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
        step(g);

        // M1 store then M0 load of the same word.
        do_reset();
        bus.M1_REQ = 1'b1; bus.M1_CMD = 4'b1010; bus.M1_ADDR = 32'h200;
        bus.M1_WDATA = 32'hDEAD_BEEF;
        step(g);
        bus.M0_REQ = 1'b1; bus.M0_CMD = 4'b0010; bus.M0_ADDR = 32'h200;
        step(g);
        step(g);
        check("swlw_rvalid", 32'(snap_rv0), 32'd1);
        check("swlw_rdata", snap_rd0, 32'hDEAD_BEEF);

        // Reset in the cycle after an M1 read grant.
        bus.M1_REQ = 1'b1; bus.M1_CMD = 4'b0010; bus.M1_ADDR = 32'h104;
        step(g);
        RST = 1'b1;
        step(g);
        check("rstrd_rv1", 32'(snap_rv1), 32'd0);
        check("rstrd_gnt", 32'({snap_gnt0, snap_gnt1}), 32'd0);
        RST = 1'b0;
        bus.M0_REQ = 1'b1; bus.M0_CMD = 4'b0010; bus.M1_REQ = 1'b1;
        step(g);
        check("rstrd_tie", 32'(g), 32'd0);
        bus.M0_REQ = 1'b0; bus.M1_REQ = 1'b0;
        step(g);

        // M0 byte store into the IO region.
        bus.M0_REQ = 1'b1; bus.M0_CMD = 4'b1000; bus.M0_ADDR = 32'h1100_0000;
        bus.M0_WDATA = 32'h0000_005A;
        step(g);
        check("io_write", 32'(snap_we), 32'd1);
        check("io_size", 32'(snap_size), 32'd0);
        check("io_addr", snap_addr, 32'h1100_0000);
        step(g);
        check("io_norv", 32'({snap_rv0, snap_rv1}), 32'd0);

        // Randomized traffic with lock toggling, request drops and occasional resets.
        for (int k = 0; k < 2000; k++) begin
            logic [3:0]  c;
            logic [31:0] a, w;
            RST = ($urandom_range(0, 199) == 0);
            if ($urandom_range(0, 15) == 0) bus.M1_LOCK = ~bus.M1_LOCK;
            if (!bus.M0_REQ || $urandom_range(0, 49) == 0) begin
                bus.M0_REQ = ($urandom_range(0, 99) < 55);
                rand_cmd(c, a, w);
                bus.M0_CMD = c; bus.M0_ADDR = a; bus.M0_WDATA = w;
            end
            if (!bus.M1_REQ || $urandom_range(0, 49) == 0) begin
                bus.M1_REQ = ($urandom_range(0, 99) < 70);
                rand_cmd(c, a, w);
                bus.M1_CMD = c; bus.M1_ADDR = a; bus.M1_WDATA = w;
            end
            step(g);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
